// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, runs the iREN/ihit fetch handshake and computes next PC.
// Latency: ihit in cycle n presents the instruction in cycle n+1; decode holds it until instr_done.
module instr_fetch_unit #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000,
   parameter int          CNT_W   = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic [31:0]      imemload,
   output logic             iREN,
   output logic [31:0]      imemaddr,
   output logic             instr_valid,
   output logic [5:0]       opcode,
   output logic [5:0]       funct,
   output logic [4:0]       rs,
   output logic [4:0]       rt,
   output logic [4:0]       rd,
   output logic [4:0]       shamt,
   output logic [15:0]      imm,
   output logic [31:0]      pc_plus4,
   input  logic             instr_done,
   input  logic [1:0]       PC_src,
   input  logic             bra,
   input  logic             zero,
   input  logic [31:0]      jr_addr,
   input  logic             halt,
   output logic             halted,
   output logic [CNT_W-1:0] retired,
   output logic [CNT_W-1:0] fetch_wait
);

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_EXEC   = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [31:0]      r_pc;
   logic [31:0]      r_instr;
   logic [CNT_W-1:0] r_retired;
   logic [CNT_W-1:0] r_fetch_wait;

   logic             w_ld_instr;
   logic             w_wait_inc;
   logic             w_retire;
   logic [31:0]      w_pc_plus4;
   logic [31:0]      w_br_off;
   logic [31:0]      w_br_target;
   logic             w_taken;
   logic [31:0]      w_next_pc;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      iREN         = 1'b0;
      instr_valid  = 1'b0;
      halted       = 1'b0;
      w_ld_instr   = 1'b0;
      w_wait_inc   = 1'b0;
      w_retire     = 1'b0;
      case (r_state)
         S_FETCH: begin
            iREN = 1'b1;
            if (ihit) begin
               w_ld_instr   = 1'b1;
               w_next_state = S_EXEC;
            end else begin
               w_wait_inc = 1'b1;
            end
         end
         S_EXEC: begin
            instr_valid = 1'b1;
            if (instr_done) begin
               if (halt) begin
                  w_next_state = S_HALTED;
               end else begin
                  w_retire     = 1'b1;
                  w_next_state = S_FETCH;
               end
            end
         end
         S_HALTED: begin
            halted = 1'b1;
         end
         default: begin
            w_next_state = S_FETCH;
         end
      endcase
   end

   // Branch offset is taken from the latched instruction, so it is only meaningful in EXEC.
   always_comb begin
      w_pc_plus4  = r_pc + 32'd4;
      w_br_off    = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
      w_br_target = w_pc_plus4 + w_br_off;
      w_taken     = zero ^ bra;
      case (PC_src)
         2'b00:   w_next_pc = w_pc_plus4;
         2'b01:   w_next_pc = w_taken ? w_br_target : w_pc_plus4;
         2'b10:   w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
         default: w_next_pc = {jr_addr[31:2], 2'b00};
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_pc         <= PC_INIT;
         r_instr      <= 32'd0;
         r_retired    <= '0;
         r_fetch_wait <= '0;
      end else begin
         if (w_ld_instr) begin
            r_instr <= imemload;
         end
         if (w_wait_inc && (r_fetch_wait != {CNT_W{1'b1}})) begin
            r_fetch_wait <= r_fetch_wait + CNT_W'(1);
         end
         if (w_retire) begin
            r_pc      <= w_next_pc;
            r_retired <= r_retired + CNT_W'(1);
         end
      end
   end

   assign imemaddr   = r_pc;
   assign pc_plus4   = w_pc_plus4;
   assign opcode     = r_instr[31:26];
   assign rs         = r_instr[25:21];
   assign rt         = r_instr[20:16];
   assign rd         = r_instr[15:11];
   assign shamt      = r_instr[10:6];
   assign funct      = r_instr[5:0];
   assign imm        = r_instr[15:0];
   assign retired    = r_retired;
   assign fetch_wait = r_fetch_wait;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; a second narrow-counter instance covers fetch_wait saturation.
module tb_instr_fetch_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ihit;
   logic [31:0] imemload;
   logic        instr_done;
   logic [1:0]  PC_src;
   logic        bra;
   logic        zero;
   logic [31:0] jr_addr;
   logic        halt;

   logic        iREN, instr_valid, halted;
   logic [31:0] imemaddr, pc_plus4;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   logic [31:0] retired, fetch_wait;

   logic        n_iREN, n_instr_valid, n_halted;
   logic [31:0] n_imemaddr, n_pc_plus4;
   logic [5:0]  n_opcode, n_funct;
   logic [4:0]  n_rs, n_rt, n_rd, n_shamt;
   logic [15:0] n_imm;
   logic [1:0]  n_retired, n_fetch_wait;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   instr_fetch_unit dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .iREN(iREN),
      .imemaddr(imemaddr), .instr_valid(instr_valid), .opcode(opcode), .funct(funct),
      .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .pc_plus4(pc_plus4),
      .instr_done(instr_done), .PC_src(PC_src), .bra(bra), .zero(zero),
      .jr_addr(jr_addr), .halt(halt), .halted(halted), .retired(retired),
      .fetch_wait(fetch_wait)
   );

   instr_fetch_unit #(.PC_INIT(32'h0000_0000), .CNT_W(2)) dut_narrow (
      .CLK(CLK), .RST(RST), .ihit(1'b0), .imemload(32'd0), .iREN(n_iREN),
      .imemaddr(n_imemaddr), .instr_valid(n_instr_valid), .opcode(n_opcode), .funct(n_funct),
      .rs(n_rs), .rt(n_rt), .rd(n_rd), .shamt(n_shamt), .imm(n_imm), .pc_plus4(n_pc_plus4),
      .instr_done(1'b0), .PC_src(2'b00), .bra(1'b0), .zero(1'b0),
      .jr_addr(32'd0), .halt(1'b0), .halted(n_halted), .retired(n_retired),
      .fetch_wait(n_fetch_wait)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_fetch(input logic [31:0] word);
      ihit     = 1'b1;
      imemload = word;
      step();
      ihit     = 1'b0;
   endtask

   task automatic do_exec(input logic [1:0] src, input logic b, input logic z,
                          input logic [31:0] jr, input logic h);
      PC_src     = src;
      bra        = b;
      zero       = z;
      jr_addr    = jr;
      halt       = h;
      instr_done = 1'b1;
      step();
      instr_done = 1'b0;
      halt       = 1'b0;
   endtask

   initial begin
      RST = 1'b1; ihit = 1'b0; imemload = 32'd0; instr_done = 1'b0;
      PC_src = 2'b00; bra = 1'b0; zero = 1'b0; jr_addr = 32'd0; halt = 1'b0;

      // Reset state
      #3;
      check("rst_iREN", iREN, 1);
      check("rst_instr_valid", instr_valid, 0);
      check("rst_imemaddr", imemaddr, 32'h0);
      check("rst_opcode", opcode, 0);
      check("rst_imm", imm, 0);
      check("rst_retired", retired, 0);
      check("rst_fetch_wait", fetch_wait, 0);
      check("rst_halted", halted, 0);
      check("rst_narrow_wait", n_fetch_wait, 0);
      @(negedge CLK);
      RST = 1'b0;

      // Two wait cycles then the first hit
      step();
      step();
      check("wait2_fetch_wait", fetch_wait, 2);
      check("wait2_narrow_wait", n_fetch_wait, 2);
      check("wait2_iREN", iREN, 1);
      check("wait2_imemaddr", imemaddr, 32'h0);
      do_fetch(32'h2001_0005);
      check("f1_instr_valid", instr_valid, 1);
      check("f1_iREN", iREN, 0);
      check("f1_opcode", opcode, 6'h08);
      check("f1_rs", rs, 0);
      check("f1_rt", rt, 1);
      check("f1_imm", imm, 16'h0005);
      check("f1_funct", funct, 6'h05);
      check("f1_fetch_wait", fetch_wait, 2);
      check("f1_pc_plus4", pc_plus4, 32'h4);

      // Sequential retire
      do_exec(2'b00, 0, 0, 32'd0, 0);
      check("seq_pc", imemaddr, 32'h4);
      check("seq_retired", retired, 1);
      check("seq_iREN", iREN, 1);
      check("seq_instr_valid", instr_valid, 0);

      // JR to 0x10, then BEQ taken backwards
      do_fetch(32'h03E0_0008);
      check("jr_rs", rs, 31);
      check("jr_funct", funct, 6'h08);
      do_exec(2'b11, 0, 0, 32'h0000_0010, 0);
      check("jr10_pc", imemaddr, 32'h10);
      do_fetch(32'h1000_FFFC);
      check("beq_imm", imm, 16'hFFFC);
      check("beq_pc_plus4", pc_plus4, 32'h14);
      do_exec(2'b01, 0, 1, 32'd0, 0);
      check("beq_taken_pc", imemaddr, 32'h04);
      check("beq_retired", retired, 3);

      // R-type field decode, ihit ignored while holding in EXEC
      do_fetch(32'h014B_48E0);
      ihit = 1'b1; imemload = 32'hFFFF_FFFF;
      step();
      ihit = 1'b0;
      check("hold_instr_valid", instr_valid, 1);
      check("hold_rs", rs, 10);
      check("hold_rt", rt, 11);
      check("hold_rd", rd, 9);
      check("hold_shamt", shamt, 3);
      check("hold_funct", funct, 6'h20);
      check("hold_fetch_wait", fetch_wait, 2);
      do_exec(2'b11, 0, 0, 32'h0000_0010, 0);
      check("jr10b_pc", imemaddr, 32'h10);

      // BNE with zero=1 is not taken
      do_fetch(32'h1400_FFFC);
      do_exec(2'b01, 1, 1, 32'd0, 0);
      check("bne_nt_pc", imemaddr, 32'h14);
      check("bne_retired", retired, 5);

      // HALT freezes everything
      do_fetch(32'hFC00_0000);
      check("halt_opcode", opcode, 6'h3F);
      do_exec(2'b00, 0, 0, 32'd0, 1);
      check("halt_halted", halted, 1);
      check("halt_iREN", iREN, 0);
      check("halt_instr_valid", instr_valid, 0);
      for (int i = 0; i < 10; i++) begin
         ihit       = ~ihit;
         imemload   = 32'h0000_0000;
         instr_done = i[0];
         step();
         check("halt_frozen_pc", imemaddr, 32'h14);
      end
      ihit = 1'b0; instr_done = 1'b0;
      check("halt_retired", retired, 5);
      check("halt_still", halted, 1);
      check("halt_still_iREN", iREN, 0);

      // Leave HALTED via reset, reach PC=0x80 and reset mid-EXEC
      #2; RST = 1'b1; #1;
      check("rst2_halted", halted, 0);
      @(negedge CLK);
      RST = 1'b0;
      do_fetch(32'h0000_0000);
      do_exec(2'b11, 0, 0, 32'h0000_0080, 0);
      do_fetch(32'h2001_0005);
      check("mid_pc", imemaddr, 32'h80);
      check("mid_instr_valid", instr_valid, 1);
      check("mid_retired", retired, 1);
      #2; RST = 1'b1; #1;
      check("rst3_pc", imemaddr, 32'h0);
      check("rst3_instr_valid", instr_valid, 0);
      check("rst3_retired", retired, 0);
      check("rst3_opcode", opcode, 0);
      check("rst3_iREN", iREN, 1);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check("restart_pc", imemaddr, 32'h0);
      check("restart_iREN", iREN, 1);

      // Jump and JR with misaligned address
      do_fetch(32'h0000_0000);
      do_exec(2'b11, 0, 0, 32'h1000_0020, 0);
      check("j_setup_pc", imemaddr, 32'h1000_0020);
      do_fetch(32'h0800_0040);
      check("j_opcode", opcode, 6'h02);
      do_exec(2'b10, 0, 0, 32'd0, 0);
      check("j_pc", imemaddr, 32'h1000_0100);
      do_fetch(32'h0000_0000);
      do_exec(2'b11, 0, 0, 32'h0000_0043, 0);
      check("jr_align_pc", imemaddr, 32'h40);

      // PC wrap at the top of the address space
      do_fetch(32'h0000_0000);
      do_exec(2'b11, 0, 0, 32'hFFFF_FFFC, 0);
      check("wrap_setup_pc", imemaddr, 32'hFFFF_FFFC);
      do_fetch(32'h0000_0000);
      check("wrap_pc_plus4", pc_plus4, 32'h0);
      do_exec(2'b00, 0, 0, 32'd0, 0);
      check("wrap_pc", imemaddr, 32'h0);
      check("wrap_retired", retired, 5);

      // Narrow counter has sat in FETCH without ihit since the last reset
      step();
      step();
      step();
      check("narrow_saturate", n_fetch_wait, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end counterpart to the instruction decoder: owns the PC and fetches instruction words from the instruction-memory port using the iREN/ihit handshake.
- Presents the latched instruction fields (opcode, funct, rs, rt, rd, shamt, imm) to decode.
- Consumes decode/execute results (PC_src, bra, zero, jr address, halt) to compute the next PC.
- Sits between the instruction cache port and the control unit / datapath.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction and fetch-wait counters.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- ihit  in  1  instruction memory returns valid data this cycle.
- imemload  in  32  instruction word, valid when ihit=1.
- iREN  out  1  instruction read request.
- imemaddr  out  32  fetch address; always equals PC.
- instr_valid  out  1  latched instruction is presented to decode.
- opcode  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- rs, rt, rd  out  5 each  instr[25:21], instr[20:16], instr[15:11].
- shamt  out  5  instr[10:6].
- imm  out  16  instr[15:0].
- pc_plus4  out  32  PC+4; JAL link value.
- instr_done  in  1  datapath finished the presented instruction (memory op completed); qualifies the inputs below.
- PC_src  in  2  00 seq, 01 branch, 10 jump, 11 jr.
- bra  in  1  0=BEQ (taken on zero), 1=BNE (taken on !zero).
- zero  in  1  ALU zero flag.
- jr_addr  in  32  rs register value for JR.
- halt  in  1  decoded HALT.
- halted  out  1  sticky halt indication.
- retired  out  CNT_W  count of completed instructions, HALT excluded.
- fetch_wait  out  CNT_W  saturating count of cycles spent in FETCH without ihit.

Behaviour:
- Reset (async, RST=1): state=FETCH, PC=PC_INIT, instr register=0, retired=0, fetch_wait=0, halted=0. Outputs during reset: iREN=1, instr_valid=0, all field outputs 0. Reset mid-fetch or mid-execute abandons the instruction; no counter increment.
- State FETCH:
  - iREN=1, instr_valid=0.
  - ihit=1: latch imemload into the instr register, go to EXEC.
  - ihit=0: fetch_wait+1, saturating at all-ones.
  - instr_done is ignored in FETCH.
- State EXEC:
  - iREN=0, instr_valid=1; fields are driven from the instr register and stay stable until the state is left.
  - instr_done=0: hold.
  - instr_done=1 and halt=1: go to HALTED. PC unchanged, retired unchanged.
  - instr_done=1 and halt=0: PC<=next_pc, retired+1 (wraps modulo 2^CNT_W), go to FETCH.
  - ihit is ignored in EXEC.
- State HALTED: iREN=0, instr_valid=0, halted=1. PC and counters frozen. Exit only via RST.
- Fetch latency: minimum one FETCH cycle per instruction. ihit in cycle n gives instr_valid=1 in cycle n+1.
- next_pc arithmetic: all sums 32-bit modulo 2^32, wrap at 32'hFFFF_FFFC to 0.
  - pc_plus4 = PC+4.
  - br_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00}.
  - taken = zero XOR bra.
  - PC_src 00: next_pc = pc_plus4.
  - PC_src 01: next_pc = br_target if taken, else pc_plus4.
  - PC_src 10: next_pc = {pc_plus4[31:28], instr[25:0], 2'b00}.
  - PC_src 11: next_pc = {jr_addr[31:2], 2'b00}; low two bits are forced to 0.
- imemaddr = PC at all times. iREN alone qualifies the request.

Test Plan:
- Reset with PC_INIT=0, ihit after 2 wait cycles, imemload=32'h2001_0005 -> imemaddr=0; fetch_wait=2; next cycle instr_valid=1, opcode=6'h08, rt=1, imm=16'h0005.
- Sequential: instr_done=1 with PC_src=00 at PC=0 -> PC=4, retired=1, back to FETCH with iREN=1.
- BEQ at PC=32'h10, imm=16'hFFFC: zero=1, bra=0 -> PC=32'h04. Repeat with zero=1, bra=1 -> PC=32'h14.
- Jump: PC=32'h1000_0020, instr=32'h0800_0040 (J), PC_src=10 -> PC=32'h1000_0100. JR with jr_addr=32'h0000_0043 -> PC=32'h40.
- HALT: instr_done=1, halt=1 at retired=5 -> halted=1, iREN=0, PC and retired=5 frozen for 10 cycles while ihit toggles.
- Assert RST mid-EXEC with PC=32'h80 -> immediately PC=PC_INIT, instr_valid=0, retired=0. After release, fetch restarts at PC_INIT; wrap case PC=32'hFFFF_FFFC seq -> PC=0.
